// File: rtl/xrek_frame_rx_if.sv
// Record output stream of the XR-BUS frame receiver: head-of-FIFO record plus
// the consumer's accept handshake.
interface xrek_frame_rx_if;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [31:0] out_w0;
  logic [31:0] out_w1;
  logic [31:0] out_w2;
  logic [31:0] out_w3;

  modport master (output out_valid, out_kind, out_w0, out_w1, out_w2, out_w3,
                  input  out_ready);
  modport slave  (input  out_valid, out_kind, out_w0, out_w1, out_w2, out_w3,
                  output out_ready);
endinterface

// File: rtl/xrek_frame_rx.sv
// XR-BUS result frame receiver: edge-detects new frames, classifies them by
// core state, queues {kind, w0..w3} records and keeps saturating statistics.
module xrek_frame_rx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4095:0]           frame_in,
  input  logic                    frame_valid_in,
  input  logic [7:0]              xrek_state_in,
  input  logic                    clr_stats,
  xrek_frame_rx_if.master         rec,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [CNT_W-1:0]        verify_pass_cnt,
  output logic [CNT_W-1:0]        verify_fail_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

  logic         prev_valid;
  logic [127:0] prev_word;
  logic [AW:0]  wptr, rptr;
  logic [129:0] mem [DEPTH];
  logic [129:0] head;
  logic [1:0]   kind;
  logic         cap, full, pop, push, drop;
  logic         unused_hi;

  assign unused_hi = ^frame_in[4095:128];

  always_comb begin
    kind = 2'd3;
    case (xrek_state_in)
      8'd5:    kind = 2'd2;
      8'd3:    kind = 2'd1;
      8'd2:    kind = 2'd0;
      default: kind = 2'd3;
    endcase
  end

  // A held, unchanged frame is taken once; any word change or a fresh valid re-arms capture.
  assign cap  = frame_valid_in && (!prev_valid || (frame_in[127:0] != prev_word));
  // Pointers carry one extra wrap bit so full and empty differ in the level.
  assign fifo_level = wptr - rptr;
  assign full = (fifo_level == FULL_LVL);
  assign pop  = rec.out_valid && rec.out_ready;
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  assign head          = mem[rptr[AW-1:0]];
  assign rec.out_valid = (fifo_level != '0);
  assign rec.out_kind  = rec.out_valid ? head[129:128]  : 2'd0;
  assign rec.out_w0    = rec.out_valid ? head[31:0]     : 32'd0;
  assign rec.out_w1    = rec.out_valid ? head[63:32]    : 32'd0;
  assign rec.out_w2    = rec.out_valid ? head[95:64]    : 32'd0;
  assign rec.out_w3    = rec.out_valid ? head[127:96]   : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_word  <= '0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      prev_valid <= frame_valid_in;
      prev_word  <= frame_in[127:0];
      if (push) wptr <= wptr + LW'(1);
      if (pop)  rptr <= rptr + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {kind, frame_in[127:0]};
  end

  // Clear wins over any same-cycle increment; all counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow        <= 1'b0;
      drop_cnt        <= '0;
      verify_pass_cnt <= '0;
      verify_fail_cnt <= '0;
    end else if (clr_stats) begin
      overflow        <= 1'b0;
      drop_cnt        <= '0;
      verify_pass_cnt <= '0;
      verify_fail_cnt <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (push && kind == 2'd2) begin
        if (frame_in[0]) begin
          if (verify_pass_cnt != '1) verify_pass_cnt <= verify_pass_cnt + CNT_W'(1);
        end else begin
          if (verify_fail_cnt != '1) verify_fail_cnt <= verify_fail_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_xrek_frame_rx.sv
// Scoreboard bench for xrek_frame_rx: a queue-based reference model predicts
// records and statistics; a negedge monitor compares the DUT against it.
module tb_xrek_frame_rx;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct {
    logic [1:0]   kind;
    logic [127:0] w;
  } rec_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [4095:0]          frame_in;
  logic                   frame_valid_in;
  logic [7:0]             xrek_state_in;
  logic                   clr_stats;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;
  logic [CNT_W-1:0]       drop_cnt, verify_pass_cnt, verify_fail_cnt;

  xrek_frame_rx_if rec_if ();

  xrek_frame_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid_in(frame_valid_in),
    .xrek_state_in(xrek_state_in), .clr_stats(clr_stats), .rec(rec_if),
    .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt),
    .verify_pass_cnt(verify_pass_cnt), .verify_fail_cnt(verify_fail_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  rec_t exp_q[$];
  int   mlevel = 0;
  int   m_drop = 0, m_pass = 0, m_failc = 0;
  bit   m_ovf  = 0;
  bit   m_pv   = 0;
  logic [127:0] m_pw = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] kind_of(input logic [7:0] s);
    if (s == 8'd5) return 2'd2;
    if (s == 8'd3) return 2'd1;
    if (s == 8'd2) return 2'd0;
    return 2'd3;
  endfunction

  // Reference model: decides captures, acceptance and statistics each rising edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        mlevel = 0; m_drop = 0; m_pass = 0; m_failc = 0; m_ovf = 0;
        m_pv = 0; m_pw = '0;
      end else begin
        bit pop, cap;
        rec_t r;
        pop = (mlevel != 0) && rec_if.out_ready;
        cap = frame_valid_in && (!m_pv || frame_in[127:0] != m_pw);
        if (cap) begin
          r.kind = kind_of(xrek_state_in);
          r.w    = frame_in[127:0];
          if (mlevel < DEPTH || pop) begin
            exp_q.push_back(r);
            mlevel++;
            if (r.kind == 2'd2) begin
              if (r.w[0]) begin if (m_pass < MAXC) m_pass++; end
              else begin if (m_failc < MAXC) m_failc++; end
            end
          end else begin
            m_ovf = 1;
            if (m_drop < MAXC) m_drop++;
          end
        end
        if (pop) mlevel--;
        if (clr_stats) begin
          m_drop = 0; m_pass = 0; m_failc = 0; m_ovf = 0;
        end
        m_pv = frame_valid_in;
        m_pw = frame_in[127:0];
      end
    end
  end

  // Monitor: compares head record against the scoreboard and pops on accept.
  initial begin
    forever begin
      @(negedge clk);
      chk("level", 128'(fifo_level), 128'(mlevel));
      chk("out_valid", 128'(rec_if.out_valid), 128'(mlevel != 0));
      chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
      chk("pass_cnt", 128'(verify_pass_cnt), 128'(m_pass));
      chk("fail_cnt", 128'(verify_fail_cnt), 128'(m_failc));
      chk("overflow", 128'(overflow), 128'(m_ovf));
      if (rec_if.out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL head: got record expected none at %0t", $time);
        end else begin
          chk("head_kind", 128'(rec_if.out_kind), 128'(exp_q[0].kind));
          chk("head_words", {rec_if.out_w3, rec_if.out_w2, rec_if.out_w1, rec_if.out_w0},
              exp_q[0].w);
          if (rec_if.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("empty_out", {94'd0, rec_if.out_kind, rec_if.out_w3[31:0] | rec_if.out_w2
            | rec_if.out_w1 | rec_if.out_w0}, 128'd0);
      end
    end
  end

  task automatic cyc(input bit fv, input logic [127:0] w, input logic [7:0] st,
                     input bit rdy, input bit clr);
    frame_valid_in = fv;
    frame_in[127:0] = w;
    for (int i = 4; i < 128; i++) frame_in[i*32 +: 32] = $urandom;
    xrek_state_in = st;
    rec_if.out_ready = rdy;
    clr_stats = clr;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] pool [4];
    logic [7:0]   states [6];
    frame_in = '0; frame_valid_in = 0; xrek_state_in = 0; clr_stats = 0;
    rec_if.out_ready = 0;
    #1 rst = 1;
    cyc(0, '0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0);
    chk("rst_level", 128'(fifo_level), 128'd0);
    chk("rst_valid", 128'(rec_if.out_valid), 128'd0);
    rst = 0;

    // Held frame, verify pass
    for (int i = 0; i < 10; i++) cyc(1, 128'h1, 8'd5, 1, 0);
    cyc(0, '0, 0, 1, 0);
    chk("hold_pass_cnt", 128'(verify_pass_cnt), 128'd1);

    // Word change while valid held
    for (int i = 0; i < 3; i++) cyc(1, 128'h10 << 32, 8'd3, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 128'h20 << 32, 8'd3, 1, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);

    // Fill past capacity without draining
    for (int i = 0; i < 6; i++) cyc(1, 128'(i + 100), 8'd3, 0, 0);
    cyc(0, '0, 0, 0, 0);
    chk("full_level", 128'(fifo_level), 128'd4);
    chk("full_drop", 128'(drop_cnt), 128'd2);
    chk("full_ovf", 128'(overflow), 128'd1);
    // Capture and pop in the same cycle while full
    cyc(1, 128'h777, 8'd5, 1, 0);
    cyc(0, '0, 0, 0, 0);
    chk("swap_level", 128'(fifo_level), 128'd4);
    chk("swap_drop", 128'(drop_cnt), 128'd2);
    for (int i = 0; i < 6; i++) cyc(0, '0, 0, 1, 0);

    // Unknown state, then clear
    cyc(1, 128'h0, 8'd7, 1, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 1, 1);
    chk("clr_drop", 128'(drop_cnt), 128'd0);
    chk("clr_ovf", 128'(overflow), 128'd0);
    chk("clr_pass", 128'(verify_pass_cnt), 128'd0);

    // Reset with records queued and a frame held across it
    cyc(1, 128'hA1, 8'd2, 0, 0);
    cyc(1, 128'hA2, 8'd2, 0, 0);
    cyc(1, 128'hA3, 8'd2, 0, 0);
    #2 rst = 1;
    #1;
    chk("async_valid", 128'(rec_if.out_valid), 128'd0);
    chk("async_level", 128'(fifo_level), 128'd0);
    @(posedge clk); #1;
    cyc(1, 128'hA3, 8'd2, 0, 0);
    rst = 0;
    cyc(1, 128'hA3, 8'd2, 0, 0);
    chk("recap_level", 128'(fifo_level), 128'd1);
    for (int i = 0; i < 3; i++) cyc(1, 128'hA3, 8'd2, 1, 0);

    // Randomized traffic with repeats so held/unchanged frames occur
    states = '{8'd2, 8'd3, 8'd5, 8'd7, 8'd0, 8'd255};
    for (int i = 0; i < 4; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0)
        pool[$urandom_range(0, 3)] = {$urandom, $urandom, $urandom, $urandom};
      cyc($urandom_range(0, 9) < 7, pool[$urandom_range(0, 3)],
          states[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
          $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 8; i++) cyc(0, '0, 0, 1, 0);
    chk("drained", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/xrek_frame_rx.md
XREK_FRAME_RX -- requirements
Module: xrek_frame_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, record FIFO depth (power of 2, at least 2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port frame_in  in  4096  XR-BUS result frame; only bits [127:0] are decoded.
REQ-006 SHALL have port frame_valid_in  in  1  frame qualifier; may stay high for many cycles.
REQ-007 SHALL have port xrek_state_in  in  8  XREK core state sampled with the frame (2=DISCOVER, 3=ORCHESTRATE, 5=VERIFY).
REQ-008 SHALL have port clr_stats  in  1  synchronous clear of counters and the overflow flag.
REQ-009 SHALL have port out_valid  out  1  head record available.
REQ-010 SHALL have port out_ready  in  1  consumer accepts head record.
REQ-011 SHALL have port out_kind  out  2  head kind: 0=CAPABILITY, 1=ORCH_RESULT, 2=VERIFY_RESULT, 3=UNKNOWN.
REQ-012 SHALL have ports out_w0, out_w1, out_w2, out_w3  out  32 each  head frame words [31:0], [63:32], [95:64], [127:96].
REQ-013 SHALL have port fifo_level  out  $clog2(DEPTH)+1  current record count.
REQ-014 SHALL have port overflow  out  1  sticky; set when a captured frame is dropped.
REQ-015 SHALL have ports drop_cnt, verify_pass_cnt, verify_fail_cnt  out  CNT_W each  statistics.

Function
REQ-016 SHALL register frame_valid_in and frame_in[127:0] every cycle as prev_valid and prev_word.
REQ-017 SHALL capture a frame when frame_valid_in=1 and either prev_valid=0 or frame_in[127:0] differs from prev_word; a held, unchanged frame is captured exactly once.
REQ-018 SHALL classify the kind from xrek_state_in in the capture cycle: 5->2, 3->1, 2->0, any other value->3.
REQ-019 SHALL push the record {kind, w0..w3} when a frame is captured and the FIFO is not full (FIFO storage is DEPTH entries).
REQ-020 SHALL pop the head when out_valid=1 and out_ready=1.
REQ-021 SHALL drive out_valid = (fifo_level != 0) and out_kind/out_w* from the head entry, with no combinational path from the frame inputs.
REQ-022 SHALL have a latency from capture cycle to out_valid=1 of exactly 1 cycle when the FIFO is empty; there is no bypass.
REQ-023 SHALL accept a push when full if a pop occurs in the same cycle; fifo_level stays DEPTH.
REQ-024 SHALL leave fifo_level unchanged on a simultaneous push and pop when not empty; on empty only the push is effective (no pop possible).
REQ-025 SHALL drop a captured frame when the FIFO is full and there is no pop: set overflow, increment drop_cnt, leave FIFO contents unchanged.
REQ-026 SHALL wrap the read and write pointers modulo DEPTH; fifo_level SHALL be derived so that full (level=DEPTH) and empty (level=0) are distinguishable.
REQ-027 SHALL, on push of a kind-2 record, increment verify_pass_cnt if w0[0]=1 and otherwise increment verify_fail_cnt.
REQ-028 SHALL make all counters saturate at all-ones and never wrap.
REQ-029 SHALL, when clr_stats=1, zero drop_cnt, verify_pass_cnt, verify_fail_cnt and overflow next cycle; clr_stats has priority over a same-cycle increment; FIFO is unaffected.
REQ-030 SHALL leave out_w*/out_kind unchanged while out_valid=1 and out_ready=0 (stable hold).

Reset
REQ-031 SHALL, while rst=1, immediately force: pointers=0, fifo_level=0, out_valid=0, overflow=0, all counters=0, prev_valid=0, prev_word=0.
REQ-032 SHALL drive out_kind and out_w* to 0 when the FIFO is empty, including during reset.
REQ-033 SHALL discard all buffered records on reset mid-operation; after rst falls, a frame_valid_in held high since before reset is captured once as a new frame.

Verification
REQ-034 SHALL pass: frame_valid_in held 10 cycles, w0=0x1, state=5, out_ready=1 -> exactly one record, kind=2, out_valid 1 cycle after capture, verify_pass_cnt=1.
REQ-035 SHALL pass: valid held while w1 changes 0x10->0x20, state=3 -> two kind-1 records in order, w1=0x10 then 0x20.
REQ-036 SHALL pass: DEPTH=4, out_ready=0, 6 distinct frames -> fifo_level=4, drop_cnt=2, overflow=1; draining yields the first 4 frames in order.
REQ-037 SHALL pass: FIFO full, capture and pop in the same cycle -> level stays 4, drop_cnt unchanged, new frame appears last.
REQ-038 SHALL pass: state=7 with w0=0x0 -> kind=3, no verify counter change; then clr_stats -> all counters 0, overflow 0.
REQ-039 SHALL pass: rst asserted with 3 records queued -> out_valid=0 and level=0 in the same cycle; the held frame is recaptured after release.
